// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: shares one memory port between an instruction master and a
// data master. Round-robin on ties, one access in flight, bounded wait with a
// sticky timeout flag.
//
// state | meaning
// IDLE  | no access; arbitrate between pending strobes
// ACC_I | instruction access on the memory port, waiting for mem_rdy_i
// ACC_D | data access on the memory port, waiting for mem_rdy_i
// DONE  | ack cycle; both strobes ignored, back to IDLE next edge
//
// Wait handling: the counter counts ACC cycles seen with mem_rdy_i=0. On the
// edge where the counter already equals TIMEOUT, a late mem_rdy_i still counts
// as normal completion; otherwise the access is abandoned as timed out.
module cpu_mem_arbiter #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              instr_stb_i,
    input  logic              instr_we_i,
    input  logic [ADDR_W-1:0] instr_addr_i,
    input  logic [DATA_W-1:0] instr_data_i,
    output logic [DATA_W-1:0] instr_data_o,
    output logic              instr_ack_o,
    input  logic              data_stb_i,
    input  logic              data_we_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_data_i,
    output logic [DATA_W-1:0] data_data_o,
    output logic              data_ack_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_rdy_i,
    output logic              timeout_o
);

    typedef enum logic [1:0] {IDLE, ACC_I, ACC_D, DONE} state_t;

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    state_t            r_state;
    state_t            w_next;
    logic              r_last_d;
    logic [7:0]        r_wait;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_instr_data;
    logic [DATA_W-1:0] r_data_data;
    logic              r_instr_ack;
    logic              r_data_ack;
    logic              r_timeout;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_in_acc;
    logic              w_done_ok;
    logic              w_done_to;

    assign w_in_acc  = (r_state == ACC_I) || (r_state == ACC_D);
    assign w_done_ok = w_in_acc && mem_rdy_i;
    assign w_done_to = w_in_acc && !mem_rdy_i && (r_wait == TO_CNT);

    assign mem_req_o    = w_in_acc;
    assign mem_we_o     = r_mem_we;
    assign mem_addr_o   = r_mem_addr;
    assign mem_wdata_o  = r_mem_wdata;
    assign instr_data_o = r_instr_data;
    assign data_data_o  = r_data_data;
    assign instr_ack_o  = r_instr_ack;
    assign data_ack_o   = r_data_ack;
    assign timeout_o    = r_timeout;

    // Arbitration in IDLE: a tie goes to the port not granted last.
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (r_state == IDLE) begin
            if (instr_stb_i && data_stb_i) begin
                w_grant_d = !r_last_d;
                w_grant_i = r_last_d;
            end else begin
                w_grant_i = instr_stb_i;
                w_grant_d = data_stb_i;
            end
        end
    end

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d)      w_next = ACC_D;
                else if (w_grant_i) w_next = ACC_I;
            end
            ACC_I, ACC_D: begin
                if (w_done_ok || w_done_to) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Request capture, wait counting, read-data capture, acks and timeout flag.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_last_d     <= 1'b0;
            r_wait       <= 8'd0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_instr_data <= '0;
            r_data_data  <= '0;
            r_instr_ack  <= 1'b0;
            r_data_ack   <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_instr_ack <= 1'b0;
            r_data_ack  <= 1'b0;
            if (w_grant_i) begin
                r_mem_we    <= instr_we_i;
                r_mem_addr  <= instr_addr_i;
                r_mem_wdata <= instr_data_i;
                r_wait      <= 8'd0;
                r_last_d    <= 1'b0;
            end else if (w_grant_d) begin
                r_mem_we    <= data_we_i;
                r_mem_addr  <= data_addr_i;
                r_mem_wdata <= data_data_i;
                r_wait      <= 8'd0;
                r_last_d    <= 1'b1;
            end else if (w_in_acc && !mem_rdy_i && (r_wait != TO_CNT)) begin
                r_wait <= r_wait + 8'd1;
            end
            if (w_done_ok || w_done_to) begin
                if (r_state == ACC_I) begin
                    r_instr_ack <= 1'b1;
                    if (w_done_to)     r_instr_data <= '1;
                    else if (!r_mem_we) r_instr_data <= mem_rdata_i;
                end else begin
                    r_data_ack <= 1'b1;
                    if (w_done_to)     r_data_data <= '1;
                    else if (!r_mem_we) r_data_data <= mem_rdata_i;
                end
                if (w_done_to) r_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: two random masters and a random-latency memory responder.
// A transaction-level model predicts which port wins each grant, what the
// memory port must show, and what each ack must carry; a negedge monitor
// compares against it.
module tb_cpu_mem_arbiter;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int TO = 4;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b0;
    logic          instr_stb_i = 1'b0, instr_we_i = 1'b0;
    logic [AW-1:0] instr_addr_i = '0;
    logic [DW-1:0] instr_data_i = '0;
    logic [DW-1:0] instr_data_o;
    logic          instr_ack_o;
    logic          data_stb_i = 1'b0, data_we_i = 1'b0;
    logic [AW-1:0] data_addr_i = '0;
    logic [DW-1:0] data_data_i = '0;
    logic [DW-1:0] data_data_o;
    logic          data_ack_o;
    logic          mem_req_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i = '0;
    logic          mem_rdy_i = 1'b0;
    logic          timeout_o;

    cpu_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .instr_stb_i(instr_stb_i), .instr_we_i(instr_we_i),
        .instr_addr_i(instr_addr_i), .instr_data_i(instr_data_i),
        .instr_data_o(instr_data_o), .instr_ack_o(instr_ack_o),
        .data_stb_i(data_stb_i), .data_we_i(data_we_i),
        .data_addr_i(data_addr_i), .data_data_i(data_data_i),
        .data_data_o(data_data_o), .data_ack_o(data_ack_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_rdy_i(mem_rdy_i),
        .timeout_o(timeout_o)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Outstanding request per port (0 = instr, 1 = data).
    bit            pend_v[2];
    bit            pend_g[2];
    logic          pend_we[2];
    logic [AW-1:0] pend_addr[2];
    logic [DW-1:0] pend_wd[2];
    int            pend_iss[2];

    typedef struct {
        int            port;
        bit            we;
        bit            to;
        logic [DW-1:0] rdata;
        int            cyc;
    } comp_t;
    comp_t comp_q[$];
    int    lat_q[$];

    // Model state.
    int            last_g = 0;
    logic [DW-1:0] port_data[2];
    bit            sticky_to = 0;
    bit            in_acc = 0;
    bit            req_prev = 0;
    int            cur = 0;
    int            acc_idx = 0;
    int            lat = 0;

    // Monitor and memory responder.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            last_g = 0; sticky_to = 0; in_acc = 0; req_prev = 0;
            pend_v[0] = 0; pend_v[1] = 0; pend_g[0] = 0; pend_g[1] = 0;
            port_data[0] = '0; port_data[1] = '0;
            comp_q.delete();
            mem_rdy_i = 1'b0;
        end else begin
            if (mem_req_o && !req_prev) begin
                bit ei, ed;
                int ex;
                ei = pend_v[0] && !pend_g[0] && (pend_iss[0] < cyc);
                ed = pend_v[1] && !pend_g[1] && (pend_iss[1] < cyc);
                if (ei && ed) ex = (last_g == 0) ? 1 : 0;
                else if (ed)  ex = 1;
                else if (ei)  ex = 0;
                else          ex = -1;
                chk(ex >= 0, "grant_without_request", 1, 0);
                if (ex >= 0) begin
                    chk(mem_addr_o == pend_addr[ex], "grant_addr", mem_addr_o, pend_addr[ex]);
                    chk(mem_we_o == pend_we[ex], "grant_we", mem_we_o, pend_we[ex]);
                    chk(mem_wdata_o == pend_wd[ex], "grant_wdata", mem_wdata_o, pend_wd[ex]);
                    cur = ex;
                    pend_g[ex] = 1;
                    last_g = ex;
                    in_acc = 1;
                    acc_idx = 0;
                    lat = (lat_q.size() > 0) ? lat_q.pop_front() : $urandom_range(0, 6);
                end
            end else if (in_acc) begin
                chk(mem_req_o == 1'b1, "req_held", mem_req_o, 1);
                chk(mem_addr_o == pend_addr[cur], "addr_stable", mem_addr_o, pend_addr[cur]);
                chk(mem_wdata_o == pend_wd[cur], "wdata_stable", mem_wdata_o, pend_wd[cur]);
                chk(mem_we_o == pend_we[cur], "we_stable", mem_we_o, pend_we[cur]);
            end else begin
                chk(mem_req_o == 1'b0, "req_outside_access", mem_req_o, 0);
            end
            req_prev = mem_req_o;

            if (instr_ack_o || data_ack_o) begin
                int p;
                p = data_ack_o ? 1 : 0;
                chk(!(instr_ack_o && data_ack_o), "both_acks", 1, 0);
                if (comp_q.size() == 0) begin
                    chk(0, "unexpected_ack_port", p, 0);
                end else begin
                    comp_t c;
                    c = comp_q.pop_front();
                    chk(p == c.port, "ack_port", p, c.port);
                    chk(cyc == c.cyc, "ack_cycle", cyc, c.cyc);
                    if (c.to)       port_data[c.port] = '1;
                    else if (!c.we) port_data[c.port] = c.rdata;
                    if (c.to) sticky_to = 1;
                    pend_v[c.port] = 0;
                    pend_g[c.port] = 0;
                end
            end
            chk(timeout_o == sticky_to, "timeout_flag", timeout_o, sticky_to);
            chk(instr_data_o == port_data[0], "instr_data", instr_data_o, port_data[0]);
            chk(data_data_o == port_data[1], "data_data", data_data_o, port_data[1]);

            // Drive the memory response for the coming edge.
            mem_rdata_i = DW'($urandom);
            if (in_acc) begin
                if (acc_idx == lat && lat <= TO) begin
                    mem_rdy_i = 1'b1;
                    comp_q.push_back('{cur, pend_we[cur], 1'b0, mem_rdata_i, cyc + 1});
                    in_acc = 0;
                end else begin
                    mem_rdy_i = 1'b0;
                    if (acc_idx == TO) begin
                        comp_q.push_back('{cur, pend_we[cur], 1'b1, '0, cyc + 1});
                        in_acc = 0;
                    end
                end
                acc_idx++;
            end else begin
                mem_rdy_i = ($urandom_range(0, 3) == 0);
            end
        end
    end

    task automatic issue(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend_we[p] = we; pend_addr[p] = a; pend_wd[p] = d;
        pend_iss[p] = cyc; pend_g[p] = 0; pend_v[p] = 1;
        if (p == 0) begin
            instr_we_i = we; instr_addr_i = a; instr_data_i = d; instr_stb_i = 1'b1;
        end else begin
            data_we_i = we; data_addr_i = a; data_data_i = d; data_stb_i = 1'b1;
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic do_txn(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok;
        ok = 0;
        issue(p, we, a, d);
        for (int k = 0; k < 60; k++) begin
            @(negedge sys_clk);
            if ((p == 0) ? instr_ack_o : data_ack_o) begin
                ok = 1;
                break;
            end
        end
        if (p == 0) instr_stb_i = 1'b0;
        else        data_stb_i = 1'b0;
        chk(ok, "ack_wait_expired", ok, 1);
        @(posedge sys_clk); #1;
    endtask

    task automatic master(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            int g;
            logic          we;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            g = $urandom_range(0, 3);
            repeat (g) begin @(posedge sys_clk); #1; end
            we = 1'($urandom_range(0, 1));
            a  = AW'($urandom);
            d  = DW'($urandom);
            do_txn(p, we, a, d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_watchdog actual=expired expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge sys_clk);
        #1;
        chk(mem_req_o == 1'b0, "rst_req", mem_req_o, 0);
        chk(mem_we_o == 1'b0, "rst_we", mem_we_o, 0);
        chk(mem_addr_o == '0, "rst_addr", mem_addr_o, 0);
        chk(mem_wdata_o == '0, "rst_wdata", mem_wdata_o, 0);
        chk(instr_ack_o == 1'b0 && data_ack_o == 1'b0, "rst_ack", {instr_ack_o, data_ack_o}, 0);
        chk(instr_data_o == '0 && data_data_o == '0, "rst_data", {instr_data_o, data_data_o}, 0);
        chk(timeout_o == 1'b0, "rst_timeout", timeout_o, 0);
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;

        // Simultaneous first requests: data must win.
        fork
            do_txn(0, 1'b0, 16'h0100, 16'h0);
            do_txn(1, 1'b0, 16'h0200, 16'h0);
        join

        // Single instruction read with minimum latency.
        lat_q.push_back(0);
        do_txn(0, 1'b0, 16'h0010, 16'h0);

        // Data write after three wait cycles.
        lat_q.push_back(3);
        do_txn(1, 1'b1, 16'h03FF, 16'h1234);

        // Late ready exactly at the timeout boundary completes normally.
        lat_q.push_back(TO);
        do_txn(1, 1'b0, 16'h0042, 16'h0);

        // No ready at all: timeout.
        lat_q.push_back(50);
        do_txn(1, 1'b0, 16'h0044, 16'h0);

        // Back-to-back instruction requests.
        do_txn(0, 1'b0, 16'h0A00, 16'h0);
        do_txn(0, 1'b1, 16'h0A02, 16'h5555);

        // Random traffic from both masters.
        fork
            master(0, 40);
            master(1, 40);
        join

        // Reset in the middle of a data access.
        lat_q.push_back(50);
        issue(1, 1'b0, 16'h0777, 16'h0);
        @(posedge sys_clk);
        @(negedge sys_clk);
        chk(mem_req_o == 1'b1, "pre_rst_req", mem_req_o, 1);
        #2 sys_rst = 1'b0;
        #1;
        chk(mem_req_o == 1'b0, "rst_mid_req", mem_req_o, 0);
        chk(data_ack_o == 1'b0, "rst_mid_ack", data_ack_o, 0);
        chk(timeout_o == 1'b0, "rst_mid_timeout", timeout_o, 0);
        data_stb_i = 1'b0;
        repeat (2) begin
            @(negedge sys_clk);
            chk(data_ack_o == 1'b0 && mem_req_o == 1'b0, "rst_hold_quiet",
                {data_ack_o, mem_req_o}, 0);
        end
        @(posedge sys_clk); #1;
        sys_rst = 1'b1;
        lat_q.delete();
        @(posedge sys_clk); #1;
        lat_q.push_back(1);
        do_txn(0, 1'b0, 16'h0123, 16'h0);

        repeat (3) @(posedge sys_clk);
        #1;
        chk(comp_q.size() == 0, "leftover_completions", comp_q.size(), 0);
        chk(pend_v[0] == 0 && pend_v[1] == 0, "leftover_requests", {pend_v[0], pend_v[1]}, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
